mc_flit_injector: RTL and testbench

- Source-side multicast injector: the transmitter feeding a router's route-computation stage.
- Accepts host multicast requests (header, 16-bit destination bitmap, 8-bit payload) and buffers them in a DEPTH-entry FIFO.
- Packs each request into a 30-bit flit and presents it under rc_ready backpressure.
- Drops requests whose destination bitmap is empty.

---
 rtl/mc_pkg.sv | 23 ++
 rtl/mc_sync_fifo.sv | 45 ++++
 rtl/mc_flit_injector.sv | 92 +++++++++
 tb/tb_mc_flit_injector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared flit layout, FSM encoding and request record for the multicast injector.
package mc_pkg;
    localparam int DATASIZE = 30;
    localparam int HDR_MSB  = 29;
    localparam int HDR_LSB  = 25;
    localparam int DST_MSB  = 24;
    localparam int DST_LSB  = 9;
    localparam int PAY_MSB  = 8;
    localparam int PAY_LSB  = 1;
    localparam int VLD_BIT  = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } inj_state_e;

    // Field order matches flit_out[29:1] so a FIFO entry maps straight onto the flit.
    typedef struct packed {
        logic [4:0]  hdr;
        logic [15:0] dst;
        logic [7:0]  pay;
    } mc_req_t;
endpackage

// File: rtl/mc_sync_fifo.sv
// Single-clock request FIFO with occupancy count; read data is the head entry.
module mc_sync_fifo
    import mc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             rc_clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  mc_req_t          wr_data,
    output mc_req_t          rd_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH:0]   count
);
    mc_req_t          mem [DEPTH];
    logic [WIDTH-1:0] wr_ptr, rd_ptr;

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge rc_clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (WIDTH+1)'(DEPTH));
    assign empty   = (count == '0);
endmodule

// File: rtl/mc_flit_injector.sv
// Source-side multicast injector: buffers host requests, drops empty bitmaps,
// and presents packed flits to route computation under rc_ready backpressure.
module mc_flit_injector #(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 2,
    parameter int DATASIZE  = 30,
    parameter int router_ID = 6
) (
    input  logic                rc_clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [4:0]          req_hdr,
    input  logic [15:0]         req_dst_list,
    input  logic [7:0]          req_payload,
    output logic [DATASIZE-1:0] flit_out,
    output logic                flit_valid,
    input  logic                rc_ready,
    output logic [WIDTH:0]      fifo_count,
    output logic [7:0]          drop_cnt,
    output logic [15:0]         sent_cnt
);
    import mc_pkg::*;

    if (DEPTH != 2**WIDTH || DATASIZE != 30 || router_ID < 0) begin : g_bad_cfg
        $error("mc_flit_injector: unsupported DEPTH/WIDTH/DATASIZE/router_ID");
    end

    inj_state_e state, state_nxt;
    mc_req_t    wr_req, rd_req;
    logic       fifo_full, fifo_empty;
    logic       rdy_en, accept, drop, push, pop, xfer;

    assign wr_req  = '{hdr: req_hdr, dst: req_dst_list, pay: req_payload};
    // Held low through reset and for the first edge after release.
    assign req_ready = rdy_en && !fifo_full;
    assign accept  = req_valid && req_ready;
    assign drop    = accept && (req_dst_list == '0);
    assign push    = accept && (req_dst_list != '0);
    assign xfer    = flit_valid && rc_ready;

    mc_sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .rc_clk  (rc_clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_req),
        .rd_data (rd_req),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
                pop       = 1'b1;
                state_nxt = SEND;
            end
            SEND: if (xfer) begin
                if (!fifo_empty) pop = 1'b1;
                else             state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only the valid bit is cleared on drain; payload bits keep their last value.
    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_out <= '0;
            rdy_en   <= 1'b0;
            drop_cnt <= '0;
            sent_cnt <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (pop)                        flit_out <= {rd_req, 1'b1};
            else if (state == SEND && xfer) flit_out[VLD_BIT] <= 1'b0;
            if (drop && drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 1'b1;
            if (xfer)                       sent_cnt <= sent_cnt + 1'b1;
        end
    end

    assign flit_valid = flit_out[VLD_BIT];
endmodule

// File: tb/tb_mc_flit_injector.sv
// Directed self-checking bench for mc_flit_injector.
module tb_mc_flit_injector;
    logic        rc_clk = 1'b0;
    logic        rst_n  = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_hdr = '0;
    logic [15:0] req_dst_list = '0;
    logic [7:0]  req_payload = '0;
    logic [29:0] flit_out;
    logic        flit_valid;
    logic        rc_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_cnt;
    logic [15:0] sent_cnt;

    int n_cmp = 0;
    int n_err = 0;

    mc_flit_injector #(.DEPTH(4), .WIDTH(2), .DATASIZE(30), .router_ID(6)) dut (
        .rc_clk       (rc_clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_hdr      (req_hdr),
        .req_dst_list (req_dst_list),
        .req_payload  (req_payload),
        .flit_out     (flit_out),
        .flit_valid   (flit_valid),
        .rc_ready     (rc_ready),
        .fifo_count   (fifo_count),
        .drop_cnt     (drop_cnt),
        .sent_cnt     (sent_cnt)
    );

    always #5 rc_clk = ~rc_clk;

    task automatic step();
        @(posedge rc_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] h, input logic [15:0] d, input logic [7:0] p);
        req_valid    = v;
        req_hdr      = h;
        req_dst_list = d;
        req_payload  = p;
    endtask

    initial begin
        logic [29:0] exp_flit;
        int          seen;
        logic [15:0] seen_dst;

        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_flit", 32'(flit_out), 0);
        chk("rst_valid", 32'(flit_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_sent", 32'(sent_cnt), 0);
        chk("rst_ready", 32'(req_ready), 0);
        step(); step();
        rst_n = 1'b1;
        chk("ready_at_release", 32'(req_ready), 0);
        step();
        chk("ready_after_release", 32'(req_ready), 1);

        // single request, 2-edge latency to flit_valid
        rc_ready = 1'b1;
        drive(1'b1, 5'h03, 16'h0010, 8'hA5);
        step();
        drive(1'b0, 5'h00, 16'h0000, 8'h00);
        chk("single_count_N", 32'(fifo_count), 1);
        chk("single_valid_N", 32'(flit_valid), 0);
        step();
        exp_flit = {5'h03, 16'h0010, 8'hA5, 1'b1};
        chk("single_flit", 32'(flit_out), 32'(exp_flit));
        chk("single_valid", 32'(flit_valid), 1);
        step();
        chk("single_drained", 32'(flit_valid), 0);
        chk("single_sent", 32'(sent_cnt), 1);

        // backpressure: 5 requests, output reg holds dst=1, FIFO full
        rc_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 5'(i), 16'(i), 8'(i));
            step();
        end
        drive(1'b0, 5'h00, 16'h0000, 8'h00);
        chk("bp_count", 32'(fifo_count), 4);
        chk("bp_ready", 32'(req_ready), 0);
        chk("bp_dst1", 32'(flit_out[24:9]), 1);
        step();
        chk("bp_hold", 32'(flit_out), 32'({5'd1, 16'd1, 8'd1, 1'b1}));
        rc_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            step();
            chk("bp_order", 32'(flit_out[24:9]), 32'(k));
            chk("bp_b2b_valid", 32'(flit_valid), 1);
        end
        step();
        chk("bp_drained", 32'(flit_valid), 0);
        chk("bp_sent", 32'(sent_cnt), 6);

        // drop: empty bitmaps interleaved with one real request
        seen = 0;
        seen_dst = '0;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 2, 3: drive(1'b1, 5'h1F, 16'h0000, 8'h77);
                1:       drive(1'b1, 5'h0A, 16'h8000, 8'h3C);
                default: drive(1'b0, 5'h00, 16'h0000, 8'h00);
            endcase
            step();
            if (flit_valid) begin
                seen++;
                seen_dst = flit_out[24:9];
            end
        end
        chk("drop_cnt", 32'(drop_cnt), 3);
        chk("drop_seen_n", 32'(seen), 1);
        chk("drop_seen_dst", 32'(seen_dst), 32'h8000);

        // drop counter saturation
        drive(1'b1, 5'h01, 16'h0000, 8'h01);
        for (int i = 0; i < 300; i++) step();
        drive(1'b0, 5'h00, 16'h0000, 8'h00);
        chk("drop_sat", 32'(drop_cnt), 255);
        chk("drop_sat_count", 32'(fifo_count), 0);

        // simultaneous push/pop at fifo_count==2
        rc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'h02, 16'(16'h0100 + i), 8'(i));
            step();
        end
        chk("pp_prefill_count", 32'(fifo_count), 2);
        chk("pp_prefill_head", 32'(flit_out[24:9]), 32'h0100);
        rc_ready = 1'b1;
        for (int i = 3; i < 6; i++) begin
            drive(1'b1, 5'h02, 16'(16'h0100 + i), 8'(i));
            step();
            chk("pp_count", 32'(fifo_count), 2);
            chk("pp_order", 32'(flit_out[24:9]), 32'(16'h0100 + i - 2));
        end
        drive(1'b0, 5'h00, 16'h0000, 8'h00);
        for (int i = 4; i < 6; i++) begin
            step();
            chk("pp_drain_order", 32'(flit_out[24:9]), 32'(16'h0100 + i));
        end
        step();
        chk("pp_idle", 32'(flit_valid), 0);
        chk("pp_sent", 32'(sent_cnt), 13);

        // async reset mid-transfer
        rc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'h04, 16'(16'h0200 + i), 8'(i));
            step();
        end
        drive(1'b0, 5'h00, 16'h0000, 8'h00);
        chk("ar_pre_valid", 32'(flit_valid), 1);
        chk("ar_pre_count", 32'(fifo_count), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_flit", 32'(flit_out), 0);
        chk("ar_valid", 32'(flit_valid), 0);
        chk("ar_count", 32'(fifo_count), 0);
        chk("ar_drop", 32'(drop_cnt), 0);
        chk("ar_sent", 32'(sent_cnt), 0);
        chk("ar_ready", 32'(req_ready), 0);
        step(); step();
        rst_n = 1'b1;
        rc_ready = 1'b1;
        step();
        chk("ar_ready_after", 32'(req_ready), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ar_no_stale", 32'(flit_valid), 0);
            chk("ar_count_after", 32'(fifo_count), 0);
        end
        chk("ar_sent_after", 32'(sent_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
